// File: rtl/vga_fb_reader.sv
// vga_fb_reader: 640x480 VGA timing generator that scans a 320x240 frame buffer with 2x pixel doubling.
// Optional feature: define TEST_PATTERN_EN to add the test_mode input and an eight-bar colour pattern.
module vga_fb_reader #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int FB_W       = 320,
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET_N,
`ifdef TEST_PATTERN_EN
  input  logic                  test_mode,
`endif
  output logic [ADDR_WIDTH-1:0] fb_addr,
  output logic                  fb_en,
  output logic                  fb_we,
  input  logic [DATA_WIDTH-1:0] fb_data,
  output logic                  VGA_CLK,
  output logic                  VGA_HS,
  output logic                  VGA_VS,
  output logic                  VGA_BLANK_N,
  output logic                  VGA_SYNC_N,
  output logic [7:0]            VGA_R,
  output logic [7:0]            VGA_G,
  output logic [7:0]            VGA_B,
  output logic                  frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int HS_BEG  = H_ACTIVE + H_FP;
  localparam int HS_END  = HS_BEG + H_SYNC;
  localparam int VS_BEG  = V_ACTIVE + V_FP;
  localparam int VS_END  = VS_BEG + V_SYNC;

  logic                  phase;
  logic                  pix_tick;
  logic [HW-1:0]         h_cnt;
  logic [VW-1:0]         v_cnt;
  logic                  h_last;
  logic                  v_last;
  logic                  active;
  logic                  hs_n;
  logic                  vs_n;
  logic                  en_next;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic                  act_q;
  logic                  hs_q;
  logic                  vs_q;
  logic [23:0]           rgb_next;

  assign pix_tick   = phase;
  assign fb_we      = 1'b0;
  assign VGA_SYNC_N = 1'b0;
  assign h_last     = h_cnt == HW'(H_TOTAL - 1);
  assign v_last     = v_cnt == VW'(V_TOTAL - 1);
  assign active     = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
  assign hs_n       = !((h_cnt >= HW'(HS_BEG)) && (h_cnt < HW'(HS_END)));
  assign vs_n       = !((v_cnt >= VW'(VS_BEG)) && (v_cnt < VW'(VS_END)));
  // Each frame-buffer pixel covers a 2x2 block of screen pixels.
  assign addr_next  = ADDR_WIDTH'(v_cnt >> 1) * ADDR_WIDTH'(FB_W) + ADDR_WIDTH'(h_cnt >> 1);

`ifdef TEST_PATTERN_EN
  logic       tm_q;
  logic [2:0] bar;
  logic [2:0] bar_rgb_q;

  assign bar      = 3'(h_cnt / HW'(H_ACTIVE / 8));
  assign en_next  = active && !test_mode;
  assign rgb_next = !act_q ? 24'h0 :
                    tm_q   ? {{8{bar_rgb_q[2]}}, {8{bar_rgb_q[1]}}, {8{bar_rgb_q[0]}}} :
                             {3{8'(fb_data)}};

  // Bar colour is decided with the address so it lines up with fetched pixel data.
  always_ff @(posedge CLOCK_50 or negedge RESET_N)
    if (!RESET_N) begin
      tm_q      <= 1'b0;
      bar_rgb_q <= 3'b000;
    end else if (pix_tick) begin
      tm_q      <= test_mode;
      bar_rgb_q <= {~bar[1], ~bar[2], ~bar[0]};
    end
`else
  assign en_next  = active;
  assign rgb_next = act_q ? {3{8'(fb_data)}} : 24'h0;
`endif

  // Pixel clock divider: phase high marks the pixel-advance cycle.
  always_ff @(posedge CLOCK_50 or negedge RESET_N)
    if (!RESET_N) begin
      phase   <= 1'b0;
      VGA_CLK <= 1'b0;
    end else begin
      phase   <= ~phase;
      VGA_CLK <= phase;
    end

  // Raster position counters.
  always_ff @(posedge CLOCK_50 or negedge RESET_N)
    if (!RESET_N) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_tick) begin
      h_cnt <= h_last ? '0 : h_cnt + 1'b1;
      if (h_last) v_cnt <= v_last ? '0 : v_cnt + 1'b1;
    end

  // Address issue stage; sync and blank are staged alongside to match the memory latency.
  always_ff @(posedge CLOCK_50 or negedge RESET_N)
    if (!RESET_N) begin
      fb_addr     <= '0;
      fb_en       <= 1'b0;
      frame_start <= 1'b0;
      act_q       <= 1'b0;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
    end else begin
      frame_start <= pix_tick && (h_cnt == '0) && (v_cnt == '0);
      if (pix_tick) begin
        if (active) fb_addr <= addr_next;
        fb_en <= en_next;
        act_q <= active;
        hs_q  <= hs_n;
        vs_q  <= vs_n;
      end
    end

  // Output stage: one pixel period after the address, memory data is valid.
  always_ff @(posedge CLOCK_50 or negedge RESET_N)
    if (!RESET_N) begin
      {VGA_R, VGA_G, VGA_B} <= 24'h0;
      VGA_BLANK_N           <= 1'b0;
      VGA_HS                <= 1'b1;
      VGA_VS                <= 1'b1;
    end else if (pix_tick) begin
      {VGA_R, VGA_G, VGA_B} <= rgb_next;
      VGA_BLANK_N           <= act_q;
      VGA_HS                <= hs_q;
      VGA_VS                <= vs_q;
    end
endmodule

// File: tb/tb_vga_fb_reader.sv
// tb_vga_fb_reader: checks a reduced-geometry instance cycle by cycle against a raster model, and a default instance on its first lines.
module tb_vga_fb_reader;
  localparam int S_HA = 16, S_HF = 2, S_HS = 4, S_HB = 2;
  localparam int S_VA = 8,  S_VF = 1, S_VS = 2, S_VB = 2;
  localparam int S_FBW = 8;
  localparam int S_HT = S_HA + S_HF + S_HS + S_HB;
  localparam int S_VT = S_VA + S_VF + S_VS + S_VB;
  localparam int S_FT = S_HT * S_VT;
  localparam int B_HT = 800;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  logic [7:0]  ram [32];

  logic [19:0] s_addr, b_addr;
  logic        s_en, s_we, s_clk, s_hs, s_vs, s_bl, s_sn, s_fs;
  logic        b_en, b_we, b_clk, b_hs, b_vs, b_bl, b_sn, b_fs;
  logic [7:0]  s_data, s_r, s_g, s_b;
  logic [7:0]  b_data, b_r, b_g, b_b;

  always #10 clk = ~clk;

  vga_fb_reader #(
    .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
    .FB_W(S_FBW), .ADDR_WIDTH(20), .DATA_WIDTH(8)
  ) dut_s (
    .CLOCK_50(clk), .RESET_N(rst_n),
`ifdef TEST_PATTERN_EN
    .test_mode(1'b0),
`endif
    .fb_addr(s_addr), .fb_en(s_en), .fb_we(s_we), .fb_data(s_data),
    .VGA_CLK(s_clk), .VGA_HS(s_hs), .VGA_VS(s_vs), .VGA_BLANK_N(s_bl), .VGA_SYNC_N(s_sn),
    .VGA_R(s_r), .VGA_G(s_g), .VGA_B(s_b), .frame_start(s_fs)
  );

  vga_fb_reader dut_b (
    .CLOCK_50(clk), .RESET_N(rst_n),
`ifdef TEST_PATTERN_EN
    .test_mode(1'b0),
`endif
    .fb_addr(b_addr), .fb_en(b_en), .fb_we(b_we), .fb_data(b_data),
    .VGA_CLK(b_clk), .VGA_HS(b_hs), .VGA_VS(b_vs), .VGA_BLANK_N(b_bl), .VGA_SYNC_N(b_sn),
    .VGA_R(b_r), .VGA_G(b_g), .VGA_B(b_b), .frame_start(b_fs)
  );

  // Registered-read frame buffers (one clock latency, read only when enabled).
  always @(posedge clk) begin
    if (s_en) s_data <= ram[s_addr[4:0]];
    b_data <= b_addr[7:0] ^ 8'h3C;
  end

  // Clock edges since reset release.
  always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, a, e, $time);
    end
  endtask

  task automatic wait_cyc(input int t);
    int g = 0;
    while (cyc < t && g < 20000) begin
      @(negedge clk);
      g++;
    end
    if (cyc != t) begin
      total++;
      bad++;
      $display("FAIL wait_cyc actual=%0d required=%0d", cyc, t);
    end
  endtask

  function automatic bit s_act(input int h, input int v);
    return h < S_HA && v < S_VA;
  endfunction

  function automatic int s_adr(input int h, input int v);
    return (v / 2) * S_FBW + h / 2;
  endfunction

  // Raster reference model: pixel n is addressed on edge 2n+2 and displayed from edge 2n+4.
  int m_addr = 0;
  always @(negedge clk) begin
    int c, n, p, h, v, e_pix;
    bit e_en, e_fs, e_bl, e_hs, e_vs, e_clk;
    c = cyc;
    if (!rst_n) begin
      m_addr = 0;
      {e_en, e_fs, e_bl, e_clk} = 4'b0000;
      {e_hs, e_vs} = 2'b11;
      e_pix = 0;
    end else begin
      e_clk = c >= 2 && c % 2 == 0;
      if (c >= 2) begin
        n = (c - 2) / 2;
        h = n % S_HT;
        v = (n / S_HT) % S_VT;
        e_en = s_act(h, v);
        if (e_en) m_addr = s_adr(h, v);
        e_fs = c % 2 == 0 && n % S_FT == 0;
      end else begin
        e_en = 1'b0;
        e_fs = 1'b0;
      end
      if (c >= 4) begin
        p = (c - 4) / 2;
        h = p % S_HT;
        v = (p / S_HT) % S_VT;
        e_bl = s_act(h, v);
        e_pix = e_bl ? int'(ram[s_adr(h, v)]) : 0;
        e_hs = !(h >= S_HA + S_HF && h < S_HA + S_HF + S_HS);
        e_vs = !(v >= S_VA + S_VF && v < S_VA + S_VF + S_VS);
      end else begin
        e_bl = 1'b0;
        e_pix = 0;
        {e_hs, e_vs} = 2'b11;
      end
    end
    chk("m_addr", 32'(s_addr), m_addr);
    chk("m_en", 32'(s_en), 32'(e_en));
    chk("m_fs", 32'(s_fs), 32'(e_fs));
    chk("m_blank", 32'(s_bl), 32'(e_bl));
    chk("m_r", 32'(s_r), e_pix);
    chk("m_g", 32'(s_g), e_pix);
    chk("m_b", 32'(s_b), e_pix);
    chk("m_hs", 32'(s_hs), 32'(e_hs));
    chk("m_vs", 32'(s_vs), 32'(e_vs));
    chk("m_vgaclk", 32'(s_clk), 32'(e_clk));
    chk("m_we", 32'({s_we, b_we}), 0);
    chk("m_syncn", 32'({s_sn, b_sn}), 0);
  end

  // Sync pulse widths over the first line/frame, and frame_start spacing.
  int hs_lo = 0, vs_lo = 0, fs_last = 0;
  always @(negedge clk) begin
    if (!rst_n) fs_last = 0;
    else begin
      if (cyc >= 4 && cyc <= 4 + 2 * B_HT - 1 && b_hs === 1'b0) hs_lo++;
      if (cyc >= 4 && cyc <= 4 + 2 * S_FT - 1 && s_vs === 1'b0) vs_lo++;
      if (s_fs === 1'b1) begin
        if (fs_last > 0) chk("fs_period", 32'(cyc - fs_last), 32'(2 * S_FT));
        fs_last = cyc;
      end
    end
  end

  typedef struct {
    bit big;
    int h;
    int v;
    int addr;
    bit en;
  } vec_t;
  vec_t tbl [11];
  int tgt [2];

  initial begin
    int t, g;
    bit hit;
    for (int i = 0; i < 32; i++) ram[i] = 8'($urandom);
    ram[0] = 8'hA5;
    tbl[0]  = '{1'b1, 2,   0, 1,   1'b1};
    tbl[1]  = '{1'b1, 3,   0, 1,   1'b1};
    tbl[2]  = '{1'b0, 15,  1, 7,   1'b1};
    tbl[3]  = '{1'b0, 0,   2, 8,   1'b1};
    tbl[4]  = '{1'b0, 15,  7, 31,  1'b1};
    tbl[5]  = '{1'b0, 16,  7, 31,  1'b0};
    tbl[6]  = '{1'b1, 639, 0, 319, 1'b1};
    tbl[7]  = '{1'b1, 700, 0, 319, 1'b0};
    tbl[8]  = '{1'b1, 639, 1, 319, 1'b1};
    tbl[9]  = '{1'b1, 0,   2, 320, 1'b1};
    tbl[10] = '{1'b1, 640, 2, 639, 1'b0};
    tgt[0] = 5 * S_HT + 3;
    tgt[1] = 9 * S_HT + 5;

    repeat (10) @(posedge clk);
    #2;
    chk("rst_hs", 32'({s_hs, b_hs}), 3);
    chk("rst_vs", 32'({s_vs, b_vs}), 3);
    chk("rst_blank", 32'({s_bl, b_bl}), 0);
    chk("rst_rgb", {s_r, s_g, s_b, 8'h0}, 0);
    chk("rst_en", 32'({s_en, b_en}), 0);
    rst_n = 1'b1;

    wait_cyc(2);
    chk("first_addr", 32'(s_addr), 0);
    chk("first_fs", 32'({s_fs, b_fs}), 3);
    wait_cyc(4);
    chk("first_rgb", {s_r, s_g, s_b, 8'h0}, 32'hA5A5A500);
    chk("first_blank", 32'(s_bl), 1);

    for (int i = 0; i < 11; i++) begin
      t = 2 * (tbl[i].v * (tbl[i].big ? B_HT : S_HT) + tbl[i].h) + 2;
      wait_cyc(t);
      chk($sformatf("tbl%0d_addr", i), tbl[i].big ? 32'(b_addr) : 32'(s_addr), tbl[i].addr);
      chk($sformatf("tbl%0d_en", i), tbl[i].big ? 32'(b_en) : 32'(s_en), 32'(tbl[i].en));
    end
    chk("hs_width", hs_lo, 192);
    chk("vs_width", vs_lo, 2 * S_HT * 2);

    for (int k = 0; k < 2; k++) begin
      g = 0;
      hit = 1'b0;
      while (!hit && g < 3000) begin
        @(posedge clk);
        #1;
        g++;
        hit = cyc >= 2 && cyc % 2 == 0 && ((cyc - 2) / 2) % S_FT == tgt[k];
      end
      if (!hit) begin
        total++;
        bad++;
        $display("FAIL midrst_wait actual=%0d required=%0d", cyc, tgt[k]);
      end
      #2 rst_n = 1'b0;
      #1;
      chk("mid_hs", 32'(s_hs), 1);
      chk("mid_vs", 32'(s_vs), 1);
      chk("mid_blank", 32'(s_bl), 0);
      chk("mid_rgb", {s_r, s_g, s_b, 8'h0}, 0);
      chk("mid_en", 32'(s_en), 0);
      chk("mid_addr", 32'(s_addr), 0);
      chk("mid_fs", 32'(s_fs), 0);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      wait_cyc(2);
      chk("restart_fs", 32'(s_fs), 1);
      chk("restart_addr", 32'(s_addr), 0);
    end

    repeat (2 * S_FT + 50) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
